// File: rtl/branch_sequencer.sv
// ============================================================================
// Module      : branch_sequencer
// Description : Conditional-branch resolution sequencer. Accepts a branch
//               (pc, imm, funct3), borrows a shared ALU for the compare,
//               resolves taken/not-taken from the ALU zero flag and offers
//               the resolved next PC to a consumer with a valid/ack handshake.
//               Unsupported funct3 encodings produce a one-cycle illegal
//               pulse. kill aborts any operation in flight.
// Options     : STATIC_PREDICT_EN - adds req_pred_taken; a redirect is only
//               offered when the resolved direction differs from the
//               prediction supplied with the request.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module branch_sequencer #(
  parameter int XLEN = 32
) (
  input  logic            clock,
  input  logic            reset,
  // Branch request
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [XLEN-1:0] req_pc,
  input  logic [XLEN-1:0] req_imm,
  input  logic [2:0]      req_funct3,
`ifdef STATIC_PREDICT_EN
  input  logic            req_pred_taken,
`endif
  // Shared ALU
  output logic            alu_req,
  input  logic            alu_gnt,
  input  logic            alu_done,
  input  logic            alu_zero,
  // Redirect to fetch
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  input  logic            redirect_ack,
  // Control / status
  input  logic            kill,
  output logic            illegal,
  output logic            busy
);

  // Sequential-fetch step used when the branch falls through.
  localparam logic [XLEN-1:0] c_PC_STEP = XLEN'(4);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_GNT_WAIT = 2'd1,
    ST_RES_WAIT = 2'd2,
    ST_REDIRECT = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] imm_q, imm_d;
  logic [2:0]      funct3_q, funct3_d;
  logic            taken_q, taken_d;
  logic            illegal_q, illegal_d;
`ifdef STATIC_PREDICT_EN
  logic            pred_q, pred_d;
`endif

  logic            w_req_illegal;
  logic            w_taken_now;
  logic [XLEN-1:0] w_target;

  // funct3 values 010 and 011 have no branch meaning.
  assign w_req_illegal = (req_funct3[2:1] == 2'b01);

  // Direction from the ALU zero flag. EQ/LT/LTU are set up so the ALU result
  // is zero when the branch is NOT taken; NE/GE/GEU are the complements.
  always_comb begin
    w_taken_now = 1'b0;
    case (funct3_q)
      3'b000, 3'b100, 3'b110: w_taken_now = ~alu_zero;
      3'b001, 3'b101, 3'b111: w_taken_now = alu_zero;
      default:                w_taken_now = 1'b0;
    endcase
  end

  // Resolved next PC; the adders wrap naturally modulo 2^XLEN.
  assign w_target = taken_q ? (pc_q + imm_q) : (pc_q + c_PC_STEP);

  // Next-state and datapath-capture logic; kill overrides every other event.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    imm_d     = imm_q;
    funct3_d  = funct3_q;
    taken_d   = taken_q;
    illegal_d = 1'b0;
`ifdef STATIC_PREDICT_EN
    pred_d    = pred_q;
`endif

    if (kill) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            pc_d     = req_pc;
            imm_d    = req_imm;
            funct3_d = req_funct3;
`ifdef STATIC_PREDICT_EN
            pred_d   = req_pred_taken;
`endif
            if (w_req_illegal) begin
              illegal_d = 1'b1;
            end else begin
              state_d = ST_GNT_WAIT;
            end
          end
        end

        ST_GNT_WAIT: begin
          if (alu_gnt) begin
            state_d = ST_RES_WAIT;
          end
        end

        ST_RES_WAIT: begin
          if (alu_done) begin
            taken_d = w_taken_now;
`ifdef STATIC_PREDICT_EN
            // A correct prediction needs no redirect.
            state_d = (w_taken_now != pred_q) ? ST_REDIRECT : ST_IDLE;
`else
            state_d = ST_REDIRECT;
`endif
          end
        end

        ST_REDIRECT: begin
          if (redirect_ack) begin
            state_d = ST_IDLE;
          end
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State and captured-operand registers with asynchronous clear.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      pc_q      <= '0;
      imm_q     <= '0;
      funct3_q  <= '0;
      taken_q   <= 1'b0;
      illegal_q <= 1'b0;
`ifdef STATIC_PREDICT_EN
      pred_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      imm_q     <= imm_d;
      funct3_q  <= funct3_d;
      taken_q   <= taken_d;
      illegal_q <= illegal_d;
`ifdef STATIC_PREDICT_EN
      pred_q    <= pred_d;
`endif
    end
  end

  // All outputs decode directly from registers so reset clears them at once.
  assign req_ready      = (state_q == ST_IDLE);
  assign busy           = (state_q != ST_IDLE);
  assign alu_req        = (state_q == ST_GNT_WAIT);
  assign redirect_valid = (state_q == ST_REDIRECT);
  assign redirect_pc    = (state_q == ST_REDIRECT) ? w_target : '0;
  assign illegal        = illegal_q;

endmodule

`default_nettype wire
